// File: rtl/bcd_pkg.sv
// Shared definitions for the BCD operand loader: state encoding, digit constants
// and the digit range check.
package bcd_pkg;

   typedef enum logic [1:0] {
      LOAD_X  = 2'd0,
      LOAD_Y  = 2'd1,
      PRESENT = 2'd2
   } state_t;

   localparam int         DIGIT_W = 4;
   localparam logic [3:0] BCD_MAX = 4'd9;

   function automatic logic is_bcd(input logic [DIGIT_W-1:0] d);
      return (d <= BCD_MAX);
   endfunction

endpackage

// File: rtl/bcd_operand_loader.sv
// Collects two M-digit packed-BCD operands from a digit stream (MSD first) and
// presents them to the downstream BCD adder with a valid/ready handshake.
module bcd_operand_loader
   import bcd_pkg::*;
#(
   parameter int M = 3,
   parameter int N = 4 * M
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clear,
   input  logic [3:0]   digit_in,
   input  logic         digit_valid,
   output logic         digit_ready,
   output logic         digit_err,
   output logic [N-1:0] op_x,
   output logic [N-1:0] op_y,
   output logic         op_valid,
   input  logic         op_ready,
   output logic [1:0]   fsm_state
);

   // Handshakes: a digit moves when digit_valid & digit_ready at a rising edge;
   // the operand pair moves when op_valid & op_ready at a rising edge. Neither
   // ready depends combinationally on its own valid.

   localparam int               CNT_W    = $clog2(M) + 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(M - 1);

   state_t           state, state_nx;
   logic [CNT_W-1:0] cnt, cnt_nx;
   logic [N-1:0]     op_x_nx, op_y_nx;
   logic             op_valid_nx;
   logic             digit_err_nx;
   logic             accept;
   logic             transfer;

   assign digit_ready = (state != PRESENT);
   assign fsm_state   = state;
   assign accept      = digit_valid & digit_ready;
   assign transfer    = op_valid & op_ready;

   always_comb begin
      state_nx     = state;
      cnt_nx       = cnt;
      op_x_nx      = op_x;
      op_y_nx      = op_y;
      op_valid_nx  = op_valid;
      digit_err_nx = 1'b0;

      // A transfer completing alongside clear still counts; both end in LOAD_X.
      if (clear || transfer) begin
         state_nx    = LOAD_X;
         cnt_nx      = '0;
         op_x_nx     = '0;
         op_y_nx     = '0;
         op_valid_nx = 1'b0;
      end else begin
         case (state)
            LOAD_X: begin
               if (accept) begin
                  if (is_bcd(digit_in)) begin
                     op_x_nx = (op_x << DIGIT_W) | N'(digit_in);
                     if (cnt == CNT_LAST) begin
                        cnt_nx   = '0;
                        state_nx = LOAD_Y;
                     end else begin
                        cnt_nx = cnt + CNT_W'(1);
                     end
                  end else begin
                     digit_err_nx = 1'b1;
                  end
               end
            end
            LOAD_Y: begin
               if (accept) begin
                  if (is_bcd(digit_in)) begin
                     op_y_nx = (op_y << DIGIT_W) | N'(digit_in);
                     if (cnt == CNT_LAST) begin
                        cnt_nx      = '0;
                        state_nx    = PRESENT;
                        op_valid_nx = 1'b1;
                     end else begin
                        cnt_nx = cnt + CNT_W'(1);
                     end
                  end else begin
                     digit_err_nx = 1'b1;
                  end
               end
            end
            PRESENT: begin
               state_nx = PRESENT;
            end
            default: begin
               state_nx    = LOAD_X;
               cnt_nx      = '0;
               op_x_nx     = '0;
               op_y_nx     = '0;
               op_valid_nx = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= LOAD_X;
         cnt       <= '0;
         op_x      <= '0;
         op_y      <= '0;
         op_valid  <= 1'b0;
         digit_err <= 1'b0;
      end else begin
         state     <= state_nx;
         cnt       <= cnt_nx;
         op_x      <= op_x_nx;
         op_y      <= op_y_nx;
         op_valid  <= op_valid_nx;
         digit_err <= digit_err_nx;
      end
   end

endmodule

// File: tb/tb_bcd_operand_loader.sv
// Directed and randomized checks of bcd_operand_loader against a digit-queue model.
module tb_bcd_operand_loader;

   localparam int M = 3;
   localparam int N = 4 * M;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         clear = 1'b0;
   logic [3:0]   digit_in = 4'd0;
   logic         digit_valid = 1'b0;
   logic         digit_ready;
   logic         digit_err;
   logic [N-1:0] op_x;
   logic [N-1:0] op_y;
   logic         op_valid;
   logic         op_ready = 1'b0;
   logic [1:0]   fsm_state;

   int n_cmp = 0;
   int n_bad = 0;

   logic [N-1:0] exp_q[$];
   int unsigned  dq[$];

   always #5 clk = ~clk;

   bcd_operand_loader #(.M(M), .N(N)) dut (
      .clk        (clk),
      .rst        (rst),
      .clear      (clear),
      .digit_in   (digit_in),
      .digit_valid(digit_valid),
      .digit_ready(digit_ready),
      .digit_err  (digit_err),
      .op_x       (op_x),
      .op_y       (op_y),
      .op_valid   (op_valid),
      .op_ready   (op_ready),
      .fsm_state  (fsm_state)
   );

   task automatic check(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [3:0] d);
      digit_valid = 1'b1;
      digit_in    = d;
      tick();
      digit_valid = 1'b0;
   endtask

   task automatic send_seq(input logic [3:0] a, b, c, d, e, f);
      send(a); send(b); send(c); send(d); send(e); send(f);
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_valid"}, N'(op_valid), N'(0));
      check({tag, "_x"}, op_x, '0);
      check({tag, "_y"}, op_y, '0);
      check({tag, "_ready"}, N'(digit_ready), N'(1));
      check({tag, "_state"}, N'(fsm_state), N'(0));
   endtask

   // Value of len queued digits starting at first, MSD first, as packed BCD.
   function automatic logic [N-1:0] fold(input int first, input int len);
      logic [N-1:0] v;
      v = '0;
      for (int i = 0; i < len; i++) v = v * 16 + N'(dq[first + i]);
      return v;
   endfunction

   initial begin
      int sz;
      bit full;
      bit nxt_err;

      // reset
      tick(); tick();
      rst = 1'b0;
      check_idle("reset");
      check("reset_err", N'(digit_err), N'(0));

      // basic entry with downstream ready
      op_ready = 1'b1;
      send(4'd1); send(4'd2); send(4'd3); send(4'd4); send(4'd5);
      check("basic_partial_valid", N'(op_valid), N'(0));
      check("basic_partial_y", op_y, 12'h045);
      send(4'd6);
      check("basic_valid", N'(op_valid), N'(1));
      check("basic_x", op_x, 12'h123);
      check("basic_y", op_y, 12'h456);
      check("basic_ready_low", N'(digit_ready), N'(0));
      tick();
      check_idle("basic_after_xfer");

      // invalid digit dropped, then back-pressure
      op_ready = 1'b0;
      send(4'd1);
      send(4'hA);
      check("err_pulse", N'(digit_err), N'(1));
      check("err_no_shift", op_x, 12'h001);
      send(4'd2);
      check("err_one_cycle", N'(digit_err), N'(0));
      send(4'd3); send(4'd9); send(4'd9); send(4'd9);
      check("err_x", op_x, 12'h123);
      check("err_y", op_y, 12'h999);
      check("err_valid", N'(op_valid), N'(1));
      digit_valid = 1'b1;
      digit_in    = 4'd7;
      for (int i = 0; i < 5; i++) begin
         tick();
         check("hold_valid", N'(op_valid), N'(1));
         check("hold_x", op_x, 12'h123);
         check("hold_y", op_y, 12'h999);
         check("hold_ready", N'(digit_ready), N'(0));
      end
      digit_valid = 1'b0;
      op_ready    = 1'b1;
      tick();
      check_idle("hold_xfer");

      // clear mid-entry discards partial digits and the digit offered with it
      send(4'd7); send(4'd8);
      clear = 1'b1; digit_valid = 1'b1; digit_in = 4'd5;
      tick();
      clear = 1'b0; digit_valid = 1'b0;
      check_idle("clear");
      op_ready = 1'b0;
      send_seq(4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6);
      check("clear_x", op_x, 12'h123);
      check("clear_y", op_y, 12'h456);

      // reset while presenting
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_idle("rst_present");

      // digit_valid toggling
      for (int i = 0; i < 6; i++) begin
         digit_valid = 1'b1;
         digit_in    = (i < 3) ? 4'd0 : 4'd9;
         tick();
         check("toggle_err", N'(digit_err), N'(0));
         digit_valid = 1'b0;
         tick();
         check("toggle_err_gap", N'(digit_err), N'(0));
      end
      check("toggle_x", op_x, 12'h000);
      check("toggle_y", op_y, 12'h999);
      check("toggle_valid", N'(op_valid), N'(1));

      // clear together with transfer
      clear = 1'b1; op_ready = 1'b1;
      tick();
      clear = 1'b0; op_ready = 1'b0;
      check_idle("clear_xfer");

      // clear suppresses the error pulse of an invalid digit
      clear = 1'b1; digit_valid = 1'b1; digit_in = 4'hB;
      tick();
      clear = 1'b0; digit_valid = 1'b0;
      check("clear_err", N'(digit_err), N'(0));

      // randomized traffic against the digit-queue model
      dq.delete();
      exp_q.delete();
      for (int cyc = 0; cyc < 800; cyc++) begin
         digit_valid = ($urandom_range(0, 3) != 0);
         digit_in    = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(10, 15))
                                                   : 4'($urandom_range(0, 9));
         op_ready    = ($urandom_range(0, 2) == 0);
         clear       = ($urandom_range(0, 40) == 0);
         nxt_err     = 1'b0;
         full        = (dq.size() == 2 * M);
         if (full && op_ready) begin
            if (exp_q.size() >= 2) begin
               check("rand_xfer_x", op_x, exp_q.pop_front());
               check("rand_xfer_y", op_y, exp_q.pop_front());
            end
            dq.delete();
         end else if (clear) begin
            dq.delete();
            exp_q.delete();
         end else if (!full && digit_valid) begin
            if (digit_in > 4'd9) begin
               nxt_err = 1'b1;
            end else begin
               dq.push_back(int'(digit_in));
               if (dq.size() == 2 * M) begin
                  exp_q.push_back(fold(0, M));
                  exp_q.push_back(fold(M, M));
               end
            end
         end
         tick();
         sz = dq.size();
         check("rand_ready", N'(digit_ready), N'(sz < 2 * M));
         check("rand_valid", N'(op_valid), N'(sz == 2 * M));
         check("rand_err", N'(digit_err), N'(nxt_err));
         check("rand_x", op_x, fold(0, (sz < M) ? sz : M));
         check("rand_y", op_y, fold(M, (sz > M) ? sz - M : 0));
      end
      digit_valid = 1'b0;
      clear       = 1'b0;
      op_ready    = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
